// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b word/byte types and memory-bridge state encoding.
// Revision    : 1.0
// ============================================================================
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [7:0]  lc3b_byte;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT_LO = 2'd1,
        BEAT_HI = 2'd2,
        DONE    = 2'd3
    } lc3b_bridge_state;

    // Read-back value for bytes whose beat never completed.
    localparam lc3b_word BRIDGE_FILL = 16'hFFFF;

    function automatic lc3b_word beat_addr(input logic [14:0] word_addr, input logic hi);
        return {word_addr, hi};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3b_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Interface   : lc3b_mem_bridge_if
// Description : CPU word port and 8-bit physical memory port of the bridge.
// Revision    : 1.0
// ============================================================================
interface lc3b_mem_bridge_if;
    import lc3b_types::*;

    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_rdata;
    logic          mem_resp;
    logic          mem_err;

    lc3b_word      pmem_address;
    lc3b_byte      pmem_wdata;
    logic          pmem_read;
    logic          pmem_write;
    lc3b_byte      pmem_rdata;
    logic          pmem_resp;

    // Environment view: CPU requester plus physical memory responder.
    modport master (
        output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        input  mem_rdata, mem_resp, mem_err,
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        output mem_rdata, mem_resp, mem_err,
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  pmem_rdata, pmem_resp
    );

endinterface
`default_nettype wire

// File: rtl/lc3b_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_wait_timer
// Description : Per-beat wait counter; flags the last permitted wait cycle.
// Revision    : 1.0
// ============================================================================
module lc3b_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);
            localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] r_count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (count_en && (r_count != C_LIMIT)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Asserted in the cycle whose miss makes the count reach the limit.
            assign expired = count_en && (r_count == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lc3b_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_bridge
// Description : Splits 16-bit LC-3b memory requests into 8-bit pmem beats.
// Revision    : 1.0
// ============================================================================
module lc3b_mem_bridge
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    lc3b_mem_bridge_if.slave bus
);

    lc3b_bridge_state r_state;
    logic [14:0]      r_word_addr;
    lc3b_byte         r_wdata_hi;
    lc3b_byte         r_rd_lo;
    logic             r_need_hi;
    logic             r_is_write;

    lc3b_word         r_mem_rdata;
    logic             r_mem_resp;
    logic             r_mem_err;
    lc3b_word         r_pmem_address;
    lc3b_byte         r_pmem_wdata;
    logic             r_pmem_read;
    logic             r_pmem_write;

    logic             w_req;
    logic             w_strobe;
    logic             w_tmr_clear;
    logic             w_tmr_count;
    logic             w_expired;

    assign w_req       = bus.mem_read | bus.mem_write;
    assign w_strobe    = r_pmem_read | r_pmem_write;
    assign w_tmr_clear = ~w_strobe | bus.pmem_resp;
    assign w_tmr_count = w_strobe & ~bus.pmem_resp;

    lc3b_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_tmr_clear),
        .count_en (w_tmr_count),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_word_addr    <= '0;
            r_wdata_hi     <= '0;
            r_rd_lo        <= '0;
            r_need_hi      <= 1'b0;
            r_is_write     <= 1'b0;
            r_mem_rdata    <= '0;
            r_mem_resp     <= 1'b0;
            r_mem_err      <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
        end else begin
            r_mem_resp <= 1'b0;
            r_mem_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_word_addr <= bus.mem_address[15:1];
                        r_wdata_hi  <= bus.mem_wdata[15:8];
                        r_is_write  <= bus.mem_write;
                        // Reads always fetch both bytes; writes only the enabled ones.
                        r_need_hi   <= bus.mem_byte_enable[1] | ~bus.mem_write;
                        if (~bus.mem_write | bus.mem_byte_enable[0]) begin
                            r_state        <= BEAT_LO;
                            r_pmem_address <= beat_addr(bus.mem_address[15:1], 1'b0);
                            r_pmem_wdata   <= bus.mem_wdata[7:0];
                            r_pmem_read    <= ~bus.mem_write;
                            r_pmem_write   <= bus.mem_write;
                        end else if (bus.mem_byte_enable[1]) begin
                            r_state        <= BEAT_HI;
                            r_pmem_address <= beat_addr(bus.mem_address[15:1], 1'b1);
                            r_pmem_wdata   <= bus.mem_wdata[15:8];
                            r_pmem_write   <= 1'b1;
                        end else begin
                            r_state    <= DONE;
                            r_mem_resp <= 1'b1;
                        end
                    end
                end

                BEAT_LO: begin
                    if (bus.pmem_resp) begin
                        if (!r_is_write) begin
                            r_rd_lo <= bus.pmem_rdata;
                        end
                        if (!w_req) begin
                            r_state      <= IDLE;
                            r_pmem_read  <= 1'b0;
                            r_pmem_write <= 1'b0;
                        end else if (r_need_hi) begin
                            r_state        <= BEAT_HI;
                            r_pmem_address <= beat_addr(r_word_addr, 1'b1);
                            r_pmem_wdata   <= r_wdata_hi;
                        end else begin
                            r_state      <= DONE;
                            r_mem_resp   <= 1'b1;
                            r_pmem_read  <= 1'b0;
                            r_pmem_write <= 1'b0;
                        end
                    end else if (w_expired) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (!w_req) begin
                            r_state <= IDLE;
                        end else begin
                            r_state    <= DONE;
                            r_mem_resp <= 1'b1;
                            r_mem_err  <= 1'b1;
                            if (!r_is_write) begin
                                r_mem_rdata <= BRIDGE_FILL;
                            end
                        end
                    end
                end

                BEAT_HI: begin
                    if (bus.pmem_resp || w_expired) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (!w_req) begin
                            r_state <= IDLE;
                        end else begin
                            r_state    <= DONE;
                            r_mem_resp <= 1'b1;
                            // A response in the expiry cycle takes priority over the timeout.
                            r_mem_err  <= ~bus.pmem_resp;
                            if (!r_is_write) begin
                                r_mem_rdata <= bus.pmem_resp ? {bus.pmem_rdata, r_rd_lo}
                                                             : {BRIDGE_FILL[15:8], r_rd_lo};
                            end
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rdata    = r_mem_rdata;
    assign bus.mem_resp     = r_mem_resp;
    assign bus.mem_err      = r_mem_err;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3b_mem_bridge
// Description : Directed bench for lc3b_mem_bridge with a transaction-level model.
// Revision    : 1.0
// ============================================================================
module tb_lc3b_mem_bridge;

    localparam int TMO = 4;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] pmem [0:65535];
    beat_t      beat_log[$];
    beat_t      exp_beats[$];
    int         resp_waits = 0;
    int         resp_wc = 0;

    // Expectation state consumed by the per-cycle compare process.
    int          c0 = 0;
    int          exp_resp_cyc = -1;
    bit          exp_err = 1'b0;
    bit          exp_upd = 1'b0;
    logic [15:0] exp_rdata = 16'h0000;
    logic [15:0] held_rdata = 16'h0000;
    int          sb_first = 1;
    int          sb_last = 0;
    bit          sb_wr = 1'b0;
    bit          in_win;
    int          resp_count = 0;
    int          resp_seen_cyc = -1;
    bit          err_seen = 1'b0;

    // Model outputs.
    int          m_lat;
    int          m_last;
    bit          m_resp;
    bit          m_err;
    logic [15:0] m_rdata;

    lc3b_mem_bridge_if bus();

    lc3b_mem_bridge #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction outcome from the bridge rules: beat list, latency, error, read data.
    task automatic model(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [1:0] be, input int w, input int d);
        bit   hi_list[$];
        bit   stop;
        bit   hi;
        int   t;
        int   e;
        logic [15:0] ba;
        logic [7:0]  bd;
        exp_beats.delete();
        m_resp = 1'b1; m_err = 1'b0; m_rdata = 16'hFFFF; m_last = 0; m_lat = -1;
        stop = 1'b0; t = 1;
        if (!wr) begin
            hi_list.push_back(1'b0); hi_list.push_back(1'b1);
        end else begin
            if (be[0]) hi_list.push_back(1'b0);
            if (be[1]) hi_list.push_back(1'b1);
        end
        for (int i = 0; i < hi_list.size() && !stop; i++) begin
            hi = hi_list[i];
            ba = {a[15:1], hi};
            if (w >= TMO) begin
                e = t + TMO - 1;
                m_last = e;
                stop = 1'b1;
                if (d >= 0 && d <= e) m_resp = 1'b0;
                else begin m_err = 1'b1; m_lat = e + 1; end
            end else begin
                e = t + w;
                m_last = e;
                bd = wr ? (hi ? wd[15:8] : wd[7:0]) : pmem[ba];
                exp_beats.push_back('{wr: wr, a: ba, d: bd});
                if (!wr) begin
                    if (hi) m_rdata[15:8] = bd; else m_rdata[7:0] = bd;
                end
                if (d >= 0 && d <= e) begin m_resp = 1'b0; stop = 1'b1; end
                t = e + 1;
            end
        end
        if (!stop) m_lat = t;
    endtask

    task automatic run(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] be, input int w, input int d);
        int dc;
        model(wr, a, wd, be, w, d);
        resp_waits = w;
        @(negedge clk); #1;
        c0 = cyc;
        beat_log.delete();
        resp_count = 0; resp_seen_cyc = -1; err_seen = 1'b0;
        exp_resp_cyc = m_resp ? c0 + m_lat : -1;
        exp_err = m_err;
        exp_upd = m_resp && !wr;
        exp_rdata = m_rdata;
        sb_first = c0 + 1;
        sb_last = c0 + m_last;
        sb_wr = wr;
        bus.mem_address = a; bus.mem_wdata = wd; bus.mem_byte_enable = be;
        bus.mem_read = rd; bus.mem_write = wr;
        dc = m_resp ? c0 + m_lat : c0 + d;
        while (cyc < dc) @(negedge clk);
        #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        repeat (3) @(negedge clk);
        check("beat_count", beat_log.size(), exp_beats.size());
        for (int i = 0; i < exp_beats.size() && i < beat_log.size(); i++)
            check("beat", beat_log[i], exp_beats[i]);
    endtask

    // Physical memory responder: fixed wait count per beat.
    initial begin
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset || !(bus.pmem_read || bus.pmem_write)) begin
                resp_wc = 0;
                bus.pmem_resp = 1'b0;
            end else if (resp_wc >= resp_waits) begin
                bus.pmem_resp = 1'b1;
                if (bus.pmem_write) pmem[bus.pmem_address] = bus.pmem_wdata;
                else bus.pmem_rdata = pmem[bus.pmem_address];
                beat_log.push_back('{wr: bus.pmem_write, a: bus.pmem_address,
                                     d: bus.pmem_write ? bus.pmem_wdata : pmem[bus.pmem_address]});
                resp_wc = 0;
            end else begin
                bus.pmem_resp = 1'b0;
                resp_wc++;
            end
        end
    end

    // Per-cycle comparison against the model's expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cyc == exp_resp_cyc && exp_upd) held_rdata = exp_rdata;
                in_win = (cyc >= sb_first) && (cyc <= sb_last);
                check("mem_resp", bus.mem_resp, cyc == exp_resp_cyc);
                check("mem_err", bus.mem_err, (cyc == exp_resp_cyc) && exp_err);
                check("mem_rdata", bus.mem_rdata, held_rdata);
                check("pmem_strobe", bus.pmem_read | bus.pmem_write, in_win);
                if (in_win) check("pmem_dir", bus.pmem_write, sb_wr);
                if (bus.mem_resp) begin resp_count++; resp_seen_cyc = cyc; end
                if (bus.mem_err) err_seen = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) pmem[i] = 8'h00;
        pmem[16'h3002] = 8'h34;
        pmem[16'h3003] = 8'h12;
        bus.mem_address = '0; bus.mem_wdata = '0; bus.mem_byte_enable = '0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_rdata", bus.mem_rdata, 16'h0000);
        check("rst_mem_resp", bus.mem_resp, 1'b0);
        check("rst_mem_err", bus.mem_err, 1'b0);
        check("rst_pmem_address", bus.pmem_address, 16'h0000);
        check("rst_pmem_wdata", bus.pmem_wdata, 8'h00);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_pmem_write", bus.pmem_write, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait read
        run(1, 0, 16'h3002, 16'h0000, 2'b00, 0, -1);
        check("t1_latency", resp_seen_cyc - c0, 3);
        check("t1_rdata", bus.mem_rdata, 16'h1234);
        check("t1_pulses", resp_count, 1);

        // High-byte-only write
        run(0, 1, 16'h4001, 16'hBEEF, 2'b10, 0, -1);
        check("t2_nbeats", beat_log.size(), 1);
        check("t2_beat", beat_log[0], {1'b1, 16'h4001, 8'hBE});
        check("t2_pulses", resp_count, 1);

        // Empty-mask write, then full write
        run(0, 1, 16'h4000, 16'h1111, 2'b00, 0, -1);
        check("t3_latency", resp_seen_cyc - c0, 1);
        check("t3_nbeats", beat_log.size(), 0);
        run(0, 1, 16'h4000, 16'hBEEF, 2'b11, 0, -1);
        check("t3_lo", beat_log[0], {1'b1, 16'h4000, 8'hEF});
        check("t3_hi", beat_log[1], {1'b1, 16'h4001, 8'hBE});

        // Odd-address read with one wait per beat
        run(1, 0, 16'h4001, 16'h0000, 2'b01, 1, -1);
        check("t3c_rdata", bus.mem_rdata, 16'hBEEF);
        check("t3c_latency", resp_seen_cyc - c0, 5);

        // Dead pmem
        run(1, 0, 16'h3002, 16'h0000, 2'b00, 1000, -1);
        check("t4_err", err_seen, 1'b1);
        check("t4_rdata", bus.mem_rdata, 16'hFFFF);
        check("t4_latency", resp_seen_cyc - c0, 5);

        // Three waits per beat: response lands on the expiry cycle
        run(1, 0, 16'h3002, 16'h0000, 2'b00, 3, -1);
        check("t5_latency", resp_seen_cyc - c0, 9);
        check("t5_rdata", bus.mem_rdata, 16'h1234);
        check("t5_err", err_seen, 1'b0);

        // Write beat exactly one wait past the limit
        run(0, 1, 16'h6000, 16'hAB00, 2'b10, 4, -1);
        check("t5b_err", err_seen, 1'b1);
        check("t5b_nbeats", beat_log.size(), 0);

        // Request withdrawn mid-beat
        run(1, 0, 16'h3002, 16'h0000, 2'b00, 2, 2);
        check("abort_pulses", resp_count, 0);
        check("abort_nbeats", beat_log.size(), 1);

        // Read and write together act as a write
        run(1, 1, 16'h5000, 16'h77A5, 2'b01, 0, -1);
        check("rw_beat", beat_log[0], {1'b1, 16'h5000, 8'hA5});

        // Reset during the high beat
        resp_waits = 3;
        @(negedge clk); #1;
        c0 = cyc;
        beat_log.delete();
        resp_count = 0;
        exp_resp_cyc = -1; exp_upd = 1'b0; exp_err = 1'b0;
        sb_first = c0 + 1; sb_last = c0 + 6; sb_wr = 1'b0;
        bus.mem_address = 16'h3002; bus.mem_read = 1'b1;
        while (cyc < c0 + 6) @(negedge clk);
        #1;
        reset = 1'b1;
        held_rdata = 16'h0000;
        #1;
        check("rst_mid_pmem_read", bus.pmem_read, 1'b0);
        check("rst_mid_mem_resp", bus.mem_resp, 1'b0);
        check("rst_mid_addr", bus.pmem_address, 16'h0000);
        bus.mem_read = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_nbeats", beat_log.size(), 1);
        check("rst_mid_pulses", resp_count, 0);

        run(1, 0, 16'h4000, 16'h0000, 2'b00, 0, -1);
        check("post_rst_rdata", bus.mem_rdata, 16'hBEEF);
        check("post_rst_latency", resp_seen_cyc - c0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
